// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - synchronous-read instruction memory with clear sweep and program-load port
//
// Purpose:
//   Word-addressed instruction store sitting between the fetch stage and a
//   program-load port. After reset it sweeps NOP_WORD into every word, then
//   raises ready. From then on it serves registered reads (1-cycle latency,
//   one per cycle) and accepts loads. Reads are read-first against a load
//   to the same address in the same cycle.
//
// Optional feature macro: INSTR_MEM_PARITY_EN
//   Adds one even-parity bit per word, the rd_perr output and the
//   ld_par_inv fault-injection input.
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   rd_req     in   1       fetch request (sampled only while ready=1)
//   rd_addr    in   ADDR_W  fetch word address
//   rd_valid   out  1       rd_data/rd_oor valid this cycle
//   rd_data    out  DATA_W  fetched word (holds while rd_valid=0)
//   rd_oor     out  1       fetched address was >= DEPTH
//   ld_en      in   1       program-load write strobe
//   ld_addr    in   ADDR_W  load word address
//   ld_data    in   DATA_W  load word
//   ld_err     out  1       one-cycle pulse: load rejected
//   ready      out  1       clear sweep finished
//   ld_par_inv in   1       (parity build) invert stored parity of loaded word
//   rd_perr    out  1       (parity build) stored parity mismatch on read

module instr_mem_sync #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_oor,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    output logic              ready
`ifdef INSTR_MEM_PARITY_EN
    ,
    input  logic              ld_par_inv,
    output logic              rd_perr
`endif
);

    // One extra bit on the compare so DEPTH == 2**ADDR_W never wraps to 0.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic rd_addr_oor;
    logic ld_addr_oor;
    logic rd_fire;
    logic ld_we;

    assign rd_addr_oor = ({1'b0, rd_addr} >= DEPTH_X);
    assign ld_addr_oor = ({1'b0, ld_addr} >= DEPTH_X);
    assign rd_fire     = ready & rd_req;
    assign ld_we       = ready & ld_en & ~ld_addr_oor;

    // State register and sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) begin
                cnt <= cnt + ONE;
            end
        end
    end

    // Next-state logic: RUN is terminal until the next reset.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (cnt == LAST_IDX) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ready  = 1'b0;
        clr_we = 1'b0;
        case (state)
            S_CLEAR: clr_we = 1'b1;
            S_RUN:   ready  = 1'b1;
            default: clr_we = 1'b1;
        endcase
    end

    // Array write port: the sweep owns it during CLEAR, the load port in RUN.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= NOP_WORD;
        end else if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Registered read. Sampling mem before the write lands gives read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= NOP_WORD;
            rd_oor   <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            rd_oor   <= rd_fire & rd_addr_oor;
            ld_err   <= ld_en & (~ready | ld_addr_oor);
            if (rd_fire) begin
                rd_data <= rd_addr_oor ? NOP_WORD : mem[rd_addr];
            end
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[cnt] <= ^NOP_WORD;
        end else if (ld_we) begin
            par_mem[ld_addr] <= (^ld_data) ^ ld_par_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_perr <= 1'b0;
        end else begin
            rd_perr <= rd_fire & ~rd_addr_oor & (par_mem[rd_addr] != (^mem[rd_addr]));
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb/tb_instr_mem_sync.sv - self-checking bench for instr_mem_sync (two parameter sets, shared stimulus)

module tb_instr_mem_sync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req;
    logic [5:0]  rd_addr;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;

    logic        o_valid [2];
    logic [31:0] o_data  [2];
    logic        o_oor   [2];
    logic        o_err   [2];
    logic        o_ready [2];
`ifdef INSTR_MEM_PARITY_EN
    logic        ld_par_inv;
    logic        o_perr  [2];
`endif

    always #5 clk = ~clk;

    instr_mem_sync #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .NOP_WORD(32'h0000_0000)) u0 (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(o_valid[0]), .rd_data(o_data[0]), .rd_oor(o_oor[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(o_err[0]), .ready(o_ready[0])
`ifdef INSTR_MEM_PARITY_EN
        , .ld_par_inv(ld_par_inv), .rd_perr(o_perr[0])
`endif
    );

    instr_mem_sync #(.DATA_W(32), .DEPTH(40), .ADDR_W(6), .NOP_WORD(32'h0000_0013)) u1 (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(o_valid[1]), .rd_data(o_data[1]), .rd_oor(o_oor[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(o_err[1]), .ready(o_ready[1])
`ifdef INSTR_MEM_PARITY_EN
        , .ld_par_inv(ld_par_inv), .rd_perr(o_perr[1])
`endif
    );

    // Reference model: per instance, the word contents, cycles since reset
    // release, and the last delivered word.
    int          dep [2] = '{64, 40};
    logic [31:0] nop [2] = '{32'h0000_0000, 32'h0000_0013};
    logic [31:0] mdl [2][64];
    logic        bad [2][64];
    int          since [2];
    logic [31:0] last [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        rd_req = 1'b0;
        ld_en  = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) begin
                mdl[k][a] = nop[k];
                bad[k][a] = 1'b0;
            end
            since[k] = 0;
            last[k]  = nop[k];
            chk($sformatf("u%0d reset rd_valid", k), 32'(o_valid[k]), 32'd0);
            chk($sformatf("u%0d reset rd_data", k), o_data[k], nop[k]);
            chk($sformatf("u%0d reset rd_oor", k), 32'(o_oor[k]), 32'd0);
            chk($sformatf("u%0d reset ld_err", k), 32'(o_err[k]), 32'd0);
            chk($sformatf("u%0d reset ready", k), 32'(o_ready[k]), 32'd0);
`ifdef INSTR_MEM_PARITY_EN
            chk($sformatf("u%0d reset rd_perr", k), 32'(o_perr[k]), 32'd0);
`endif
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock of stimulus, then compare against the model one edge later.
    task automatic cyc(input logic req, input logic [5:0] ra, input logic ld,
                       input logic [5:0] la, input logic [31:0] ldd, input logic pinv);
        logic        ev [2];
        logic        eo [2];
        logic        ee [2];
        logic        epe [2];
        logic [31:0] ed [2];
        logic        rdy;
        rd_req  = req;
        rd_addr = ra;
        ld_en   = ld;
        ld_addr = la;
        ld_data = ldd;
`ifdef INSTR_MEM_PARITY_EN
        ld_par_inv = pinv;
`endif
        for (int k = 0; k < 2; k++) begin
            rdy    = (since[k] >= dep[k]);
            ev[k]  = rdy && req;
            eo[k]  = (int'(ra) >= dep[k]);
            ed[k]  = ev[k] ? (eo[k] ? nop[k] : mdl[k][ra]) : last[k];
            epe[k] = ev[k] && !eo[k] && bad[k][ra];
            ee[k]  = ld && (!rdy || int'(la) >= dep[k]);
            if (rdy && ld && int'(la) < dep[k]) begin
                mdl[k][la] = ldd;
                bad[k][la] = pinv;
            end
            last[k] = ed[k];
            since[k]++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d rd_valid a=%0d", k, ra), 32'(o_valid[k]), 32'(ev[k]));
            chk($sformatf("u%0d rd_data a=%0d", k, ra), o_data[k], ed[k]);
            if (ev[k]) begin
                chk($sformatf("u%0d rd_oor a=%0d", k, ra), 32'(o_oor[k]), 32'(eo[k]));
`ifdef INSTR_MEM_PARITY_EN
                chk($sformatf("u%0d rd_perr a=%0d", k, ra), 32'(o_perr[k]), 32'(epe[k]));
`endif
            end
            chk($sformatf("u%0d ld_err a=%0d", k, la), 32'(o_err[k]), 32'(ee[k]));
            chk($sformatf("u%0d ready t=%0d", k, since[k]), 32'(o_ready[k]), 32'(since[k] >= dep[k]));
        end
    endtask

    task automatic rnd_cyc(input int ld_pct);
        cyc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
            1'($urandom_range(0, 99) < ld_pct), 6'($urandom_range(0, 63)), $urandom, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b1;
        rd_req  = 1'b0;
        rd_addr = '0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
`ifdef INSTR_MEM_PARITY_EN
        ld_par_inv = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_reset();

        // Sweep with random traffic: reads ignored, loads rejected until ready.
        repeat (66) rnd_cyc(30);

        // Cleared words.
        cyc(1'b1, 6'd0,  1'b0, 6'd0, 32'h0, 1'b0);
        cyc(1'b1, 6'd31, 1'b0, 6'd0, 32'h0, 1'b0);
        cyc(1'b1, 6'd63, 1'b0, 6'd0, 32'h0, 1'b0);
        cyc(1'b0, 6'd0,  1'b0, 6'd0, 32'h0, 1'b0);

        // Load then back-to-back reads.
        cyc(1'b0, 6'd0, 1'b1, 6'd0, 32'h0400_0009, 1'b0);
        cyc(1'b0, 6'd0, 1'b1, 6'd4, 32'h08A5_0002, 1'b0);
        cyc(1'b1, 6'd0, 1'b0, 6'd0, 32'h0, 1'b0);
        cyc(1'b1, 6'd4, 1'b0, 6'd0, 32'h0, 1'b0);
        cyc(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 1'b0);

        // Same-address collision is read-first; different addresses independent.
        cyc(1'b0, 6'd0, 1'b1, 6'd5, 32'h1111_1111, 1'b0);
        cyc(1'b1, 6'd5, 1'b1, 6'd5, 32'h2222_2222, 1'b0);
        cyc(1'b1, 6'd5, 1'b1, 6'd6, 32'h3333_3333, 1'b0);
        cyc(1'b1, 6'd6, 1'b0, 6'd0, 32'h0, 1'b0);

        // Range: addr 45 and 50 are beyond u1's 40 words.
        cyc(1'b1, 6'd45, 1'b0, 6'd0, 32'h0, 1'b0);
        cyc(1'b0, 6'd0,  1'b1, 6'd50, 32'hDEAD_BEEF, 1'b0);
        cyc(1'b1, 6'd39, 1'b1, 6'd40, 32'h5555_AAAA, 1'b0);
        cyc(1'b1, 6'd40, 1'b0, 6'd0, 32'h0, 1'b0);

        // Random mixed traffic.
        repeat (300) rnd_cyc(40);

        // Reset mid-run, then again at sweep count 20.
        do_reset();
        repeat (20) rnd_cyc(50);
        do_reset();
        repeat (66) cyc(1'b1, 6'($urandom_range(0, 63)), 1'b1, 6'($urandom_range(0, 63)), $urandom, 1'b0);
        for (int a = 0; a < 64; a++) cyc(1'b1, 6'(a), 1'b0, 6'd0, 32'h0, 1'b0);

`ifdef INSTR_MEM_PARITY_EN
        cyc(1'b0, 6'd7, 1'b1, 6'd7, 32'h0000_000F, 1'b1);
        cyc(1'b1, 6'd7, 1'b0, 6'd0, 32'h0, 1'b0);
        cyc(1'b0, 6'd7, 1'b1, 6'd7, 32'h0000_000F, 1'b0);
        cyc(1'b1, 6'd7, 1'b0, 6'd0, 32'h0, 1'b0);
        repeat (50) cyc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                        1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
                        1'($urandom_range(0, 1)));
`endif

        repeat (20) rnd_cyc(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory; next generation of the core's fixed 64x32 combinational instruction store.
- Sits between the PC/fetch stage and a program-load port driven by the testbench or a boot loader.
- Adds a post-reset clear sweep, a runtime program-load write port, a registered read with a valid handshake, and out-of-range detection.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 64, number of words; need not be a power of two.
- ADDR_W, 6, address width; must satisfy 2^ADDR_W >= DEPTH.
- NOP_WORD, 0, value written to every word by the clear sweep and returned for out-of-range reads.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  fetch request; sampled only while ready=1.
- rd_addr  in  ADDR_W  fetch word address.
- rd_valid  out  1  rd_data/rd_oor valid this cycle.
- rd_data  out  DATA_W  fetched word.
- rd_oor  out  1  fetched address was >= DEPTH.
- ld_en  in  1  program-load write strobe; honoured only while ready=1.
- ld_addr  in  ADDR_W  load word address.
- ld_data  in  DATA_W  load word.
- ld_err  out  1  one-cycle pulse: load was rejected (address out of range, or ready=0).
- ready  out  1  clear sweep finished; memory accepts reads and loads.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rd_valid=0, rd_data=NOP_WORD, rd_oor=0, ld_err=0, ready=0.
  - FSM enters CLEAR; sweep counter is set to 0.
  - Array contents are not reset directly.
- FSM has two states: CLEAR and RUN.
- CLEAR state:
  - Each cycle writes NOP_WORD to word[cnt], then cnt+1.
  - After writing word DEPTH-1, moves to RUN on the next edge; ready=1 from that cycle.
  - CLEAR lasts exactly DEPTH cycles after reset release.
  - rd_req is ignored (no rd_valid).
  - ld_en pulses ld_err the next cycle; no write occurs.
- RUN state:
  - Remains in RUN until the next reset.
  - A reset asserted mid-sweep or mid-RUN restarts CLEAR from word 0.
- Read (RUN):
  - rd_req=1 at edge N gives rd_valid=1 at cycle N+1, with rd_data=word[rd_addr] and rd_oor=0.
  - Latency is fixed at 1 cycle; back-to-back requests are accepted every cycle.
  - rd_valid=0 in any cycle with no request the cycle before.
  - rd_data holds its last value while rd_valid=0.
- Out-of-range read: rd_addr >= DEPTH gives rd_valid=1, rd_data=NOP_WORD, rd_oor=1 next cycle. The array is not accessed.
- Load (RUN):
  - ld_en=1 with ld_addr < DEPTH writes word[ld_addr]=ld_data at the edge.
  - ld_addr >= DEPTH: no write; ld_err=1 the next cycle.
- Read and load to the same address in the same cycle: read-first. rd_data returns the old word; the new word is visible from the next request.
- Read and load to different addresses in the same cycle: both complete independently.
- No backpressure: the consumer must accept rd_valid data when it is presented.

Optional Feature:
- Macro: INSTR_MEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on write (both load and clear).
  - Extra output rd_perr (1 bit) is valid with rd_valid; it is 1 when the stored parity mismatches the stored data.
  - Extra input ld_par_inv (1 bit) inverts the stored parity for the word being loaded, for fault injection.
  - rd_perr=0 on reset and for out-of-range reads.
- When undefined: no parity storage, no rd_perr or ld_par_inv ports; behaviour is otherwise identical.

Test Plan:
- Clear sweep: DEPTH=64, NOP_WORD=0; release reset, poll ready -> ready rises exactly 64 cycles after release; reads of addr 0, 31 and 63 return 0x00000000 with rd_oor=0.
- Load then read: load 0x04000009 at addr 0 and 0x08A50002 at addr 4; read 0 then 4 back-to-back -> rd_valid high two consecutive cycles, data 0x04000009 then 0x08A50002, each one cycle after its request.
- Collision: word 5 = 0x11111111; same cycle load 0x22222222 to addr 5 and read addr 5 -> rd_data=0x11111111; the following read returns 0x22222222.
- Range check: DEPTH=40, ADDR_W=6; read addr 45 -> rd_valid=1, rd_data=NOP_WORD, rd_oor=1; load addr 50 -> ld_err pulses one cycle and no array word changes.
- Reset mid-operation: after loads, assert rst_n=0 for 1 cycle at sweep count 20 -> outputs return to reset values immediately; ready=0 for a full DEPTH cycles; all words read back as NOP_WORD. A load issued during CLEAR -> ld_err=1.
- Parity (INIT with INSTR_MEM_PARITY_EN): load 0x0000000F with ld_par_inv=1, then read -> rd_perr=1; reload the same word with ld_par_inv=0, then read -> rd_perr=0.
